// File: rtl/sram_like_resp.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sram_like_resp: SRAM-like slave, byte-strobed writes, in-order responses    |
// |   LATENCY cycles after each handshake. Optional stall: SRAM_LIKE_STALL_EN.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module sram_like_resp #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CDW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CDW-1:0] CD_INIT = CDW'(LATENCY - 1);

  logic [31:0]       mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] widx;
  logic              stall, full, hs, pop;

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DEPTH-1:0]  wr_q, wr_d;
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [CDW-1:0]    cd_q [DEPTH];
  logic [CDW-1:0]    cd_d [DEPTH];
  logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]     count_q, count_d;

  // size and the aliased address bits carry no meaning for this memory
  logic unused_ok;
  assign unused_ok = ^{size, addr[31:ADDR_W+2], addr[1:0]};

`ifdef SRAM_LIKE_STALL_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign widx    = addr[ADDR_W+1:2];
  assign full    = (count_q == DEPTH_C);
  assign addr_ok = req & ~full & ~stall & ~reset;
  assign hs      = req & addr_ok;
  assign data_ok = ~reset & vld_q[rptr_q] & (cd_q[rptr_q] == '0);
  assign pop     = data_ok;
  assign rdata   = (data_ok & ~wr_q[rptr_q]) ? data_q[rptr_q] : 32'h0;

  always_comb begin
    vld_d  = vld_q;
    wr_d   = wr_q;
    data_d = data_q;
    cd_d   = cd_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (cd_q[i] != '0)) cd_d[i] = cd_q[i] - 1'b1;
    end
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + 1'b1;
    end
    // read data is snapshotted at acceptance, so later writes stay invisible
    if (hs) begin
      vld_d[wptr_q]  = 1'b1;
      wr_d[wptr_q]   = wr;
      data_d[wptr_q] = wr ? 32'h0 : mem_q[widx];
      cd_d[wptr_q]   = CD_INIT;
      wptr_d         = wptr_q + 1'b1;
    end
    case ({hs, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_q   <= wr_d;
    data_q <= data_d;
    cd_q   <= cd_d;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (hs && wr && wstrb[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_resp.sv
`default_nettype none
// tb_sram_like_resp: directed checks of sram_like_resp (LATENCY 2 and 6 instances);
// with SRAM_LIKE_STALL_EN a scoreboarded random stream against an LFSR model.
module tb_sram_like_resp;

  logic        clk, reset, req, req6, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok, addr_ok6, data_ok6;
  logic [31:0] rdata, rdata6;

  int checks   = 0;
  int failures = 0;

  sram_like_resp #(.ADDR_W(10), .DEPTH(4), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_like_resp #(.ADDR_W(10), .DEPTH(4), .LATENCY(6)) u_dut6 (
    .clk(clk), .reset(reset), .req(req6), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok6), .data_ok(data_ok6), .rdata(rdata6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic r, input logic r6, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    req = r; req6 = r6; wr = w; addr = a; wstrb = s; wdata = d;
    #1;
  endtask

`ifdef SRAM_LIKE_STALL_EN
  logic [7:0] lfsr_m;
  always @(posedge clk) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end
  logic [31:0] mm [16];
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;
  logic        c_wr;
  logic [3:0]  c_idx, c_strb;
  logic [31:0] c_data;
  int          sent, got, cyc;
`else
  logic [7:0]  a6_exp;
  logic [14:0] d6_exp;
`endif

  initial begin
    size = 2'd2;
    reset = 1'b1;
    set(1'b1, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    chk1("rst_addr_ok_pre", addr_ok, 1'b0);
    chk1("rst_data_ok_pre", data_ok, 1'b0);
    nxt(); nxt();
    chk1("rst_addr_ok", addr_ok, 1'b0);
    chk1("rst_addr_ok6", addr_ok6, 1'b0);
    chk1("rst_data_ok", data_ok, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    reset = 1'b0;

`ifdef SRAM_LIKE_STALL_EN
    sent = 0; got = 0; cyc = 0;
    c_wr = 1'b1; c_idx = 4'd0; c_strb = 4'hF; c_data = $urandom;
    while (got < 64 && cyc < 3000) begin
      set(sent < 64, 1'b0, c_wr, {26'h0, c_idx, 2'b00}, c_strb, c_data);
      if (lfsr_m[0]) chk1("stall_blocks", addr_ok, 1'b0);
      else chk1("addr_ok_free", addr_ok, (sent < 64) && (exp_q.size() < 4));
      if (data_ok) begin
        if (exp_q.size() == 0) chk1("spurious_data_ok", data_ok, 1'b0);
        else begin
          exp_v = exp_q.pop_front();
          chk("stream_rdata", rdata, exp_v);
          got++;
        end
      end
      if (req && addr_ok) begin
        if (c_wr) begin
          exp_q.push_back(32'h0);
          for (int b = 0; b < 4; b++) if (c_strb[b]) mm[c_idx][8*b +: 8] = c_data[8*b +: 8];
        end else exp_q.push_back(mm[c_idx]);
        sent++;
        c_wr   = (sent < 16) ? 1'b1 : 1'($urandom_range(0, 1));
        c_idx  = (sent < 16) ? 4'(sent) : 4'($urandom_range(0, 15));
        c_strb = (sent < 16) ? 4'hF : 4'($urandom_range(0, 15));
        c_data = $urandom;
      end
      nxt();
      cyc++;
    end
    chk("stream_responses", 32'(got), 32'd64);
`else
    // write then read of one word; the write answers too
    set(1'b1, 1'b1, 1'b1, 32'h10, 4'hF, 32'h12345678);
    chk1("wr_addr_ok", addr_ok, 1'b1);
    chk1("wr_no_early", data_ok, 1'b0);
    nxt();
    set(1'b1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    chk1("rd_addr_ok", addr_ok, 1'b1);
    chk1("lat_not_t1", data_ok, 1'b0);
    nxt();
    set(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk1("wr_data_ok_t2", data_ok, 1'b1);
    chk("wr_rdata_zero", rdata, 32'h0);
    nxt();
    chk1("rd_data_ok", data_ok, 1'b1);
    chk("rd_rdata", rdata, 32'h12345678);
    nxt();
    chk1("idle_data_ok", data_ok, 1'b0);
    chk("idle_rdata", rdata, 32'h0);

    // partial strobe merge, read through an aliased address
    set(1'b1, 1'b1, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF);
    nxt();
    set(1'b1, 1'b1, 1'b1, 32'h20, 4'b0010, 32'h0000AB00);
    nxt();
    set(1'b1, 1'b1, 1'b0, 32'h1020, 4'h0, 32'h0);
    nxt();
    set(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    nxt();
    chk1("strb_data_ok", data_ok, 1'b1);
    chk("strb_rdata", rdata, 32'hFFFFABFF);
    repeat (6) nxt();

    // 8 back-to-back reads at LATENCY 2 never fill the queue
    for (int k = 0; k < 10; k++) begin
      set(k < 8, 1'b0, 1'b0, k[0] ? 32'h20 : 32'h10, 4'h0, 32'h0);
      if (k < 8) chk1("b2b_addr_ok", addr_ok, 1'b1);
      chk1("b2b_data_ok", data_ok, k >= 2);
      chk("b2b_rdata", rdata, (k < 2) ? 32'h0 : (k[0] ? 32'hFFFFABFF : 32'h12345678));
      nxt();
    end

    // LATENCY 6: fifth read waits for a pop, and not the pop cycle itself
    a6_exp = 8'h8F;
    d6_exp = 15'h23C0;
    for (int k = 0; k < 15; k++) begin
      set(1'b0, k <= 7, 1'b0, (k < 4 && k[0]) ? 32'h20 : 32'h10, 4'h0, 32'h0);
      if (k <= 7) chk1("full_addr_ok6", addr_ok6, a6_exp[k]);
      chk1("full_data_ok6", data_ok6, d6_exp[k]);
      chk("full_rdata6", rdata6, !d6_exp[k] ? 32'h0 : ((k == 7 || k == 9) ? 32'hFFFFABFF : 32'h12345678));
      nxt();
    end

    // reset with three reads in flight
    for (int k = 0; k < 3; k++) begin
      set(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
      chk1("pre_rst_addr_ok6", addr_ok6, 1'b1);
      nxt();
    end
    reset = 1'b1;
    set(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk1("mid_rst_data_ok6", data_ok6, 1'b0);
    nxt();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk1("post_rst_no_resp", data_ok6, 1'b0);
      nxt();
    end
    set(1'b0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    chk1("post_rst_addr_ok6", addr_ok6, 1'b1);
    nxt();
    set(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int j = 1; j <= 6; j++) begin
      chk1("post_rst_data_ok6", data_ok6, j == 6);
      if (j == 6) chk("post_rst_rdata6", rdata6, 32'hFFFFABFF);
      nxt();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_like_resp.md
SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address bits of the internal memory (1024 x 32).
REQ-002 SHALL have parameter DEPTH, default 4, maximum outstanding accepted-but-unanswered requests (power of 2, >=2).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from address handshake to data_ok (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  1  initiator request valid.
REQ-007 SHALL have port wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port size  input  2  access size, 0/1/2 = byte/half/word.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wstrb  input  4  write byte enables.
REQ-011 SHALL have port wdata  input  32  write data.
REQ-012 SHALL have port addr_ok  output  1  request accepted this cycle when req also high.
REQ-013 SHALL have port data_ok  output  1  one response completes this cycle.
REQ-014 SHALL have port rdata  output  32  read data, valid with data_ok.

Function
REQ-015 SHALL compute addr_ok combinationally = req & ~full & ~stall; handshake = req & addr_ok.
REQ-016 SHALL treat full as count == DEPTH, with no accept while full even if a pop occurs in the same cycle.
REQ-017 SHALL index memory with addr[ADDR_W+1:2]; upper address bits are ignored (aliasing).
REQ-018 SHALL, on a write handshake, update memory at that clock edge for bytes whose wstrb bit is 1 only.
REQ-019 SHALL ignore size for memory update (wstrb is authoritative) and always return a full word on reads.
REQ-020 SHALL, on a read handshake, capture the addressed word into the queue entry at that edge, so earlier accepted writes are visible and later writes are not.
REQ-021 SHALL push per handshake one FIFO entry {wr, data, countdown = LATENCY-1}.
REQ-022 SHALL decrement every valid entry's countdown each cycle, saturating at 0.
REQ-023 SHALL assert data_ok for exactly one cycle per entry when the head entry is valid with countdown 0, then pop it; responses are strictly in order.
REQ-024 SHALL give a response for an uncongested request at cycle T+LATENCY after a handshake in cycle T.
REQ-025 SHALL drive rdata = head data for reads and 0 for writes while data_ok is high, and 0 when data_ok is low.
REQ-026 SHALL give write entries a data_ok response, identical in timing to reads.
REQ-027 SHALL, on a simultaneous push and pop, leave count unchanged and preserve order.
REQ-028 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-029 SHALL not depend on req/wr/addr/wdata/wstrb when handshake is 0 (no state change).

Reset
REQ-030 SHALL, while reset is high, clear the FIFO (count 0, pointers 0) and hold addr_ok = 0, data_ok = 0, rdata = 0.
REQ-031 SHALL discard outstanding entries on reset mid-operation; no data_ok for them afterwards.
REQ-032 SHALL not initialise memory contents on reset.

Configuration
REQ-033 SHALL support macro SRAM_LIKE_STALL_EN.
REQ-034 SHALL, with SRAM_LIKE_STALL_EN defined, run an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset, advancing every cycle), with stall = lfsr[0].
REQ-035 SHALL, without SRAM_LIKE_STALL_EN, tie stall to 0, and no LFSR logic exists.

Verification
REQ-036 SHALL pass: reset; write addr 0x10, wstrb 4'hF, wdata 0x12345678, then read 0x10 -> write data_ok at T+2, read data_ok with rdata 0x12345678.
REQ-037 SHALL pass: word 0x20 = 0xFFFFFFFF; write wstrb 4'b0010, wdata 0x0000AB00; read -> rdata 0xFFFFABFF.
REQ-038 SHALL pass: req held high for 8 reads, data_ok never taken away (DEPTH 4, LATENCY 2) -> addr_ok never blocks beyond full, 8 data_ok in order, count never exceeds 4.
REQ-039 SHALL pass: LATENCY 6, 5 back-to-back reads -> 5th req sees addr_ok = 0 until the first data_ok pops, then accepted.
REQ-040 SHALL pass: assert reset with 3 outstanding reads -> no data_ok after reset, the next read returns data at T+LATENCY.
REQ-041 SHALL pass: with SRAM_LIKE_STALL_EN, a 64-request random stream -> addr_ok = 0 on every cycle where lfsr[0] = 1, and all 64 responses are correct and in order.
